// File: rtl/uart_tx_rr_sched.sv
// Round-robin arbiter plus 8N1 framer sharing one UART TX line between NREQ byte producers.
// Bit transitions follow rising edges of clkUtx; arbitration runs in any IDLE cycle with a pending req.
module uart_tx_rr_sched #(
    parameter int NREQ      = 3,
    parameter int IDW       = 2,
    parameter int STOP_BITS = 1,
    parameter int GAP_BITS  = 0
) (
    input  logic                clk10mhz,
    input  logic                rst_n,
    input  logic                clkUtx,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*8-1:0]   data,
    output logic [NREQ-1:0]     ack,
    output logic [IDW-1:0]      grant_id,
    output logic                busy,
    output logic                txd,
    output logic                frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        START,
        DATA,
        STOP,
        GAP
    } state_t;

    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [2:0] GAP_LAST  = (GAP_BITS > 0) ? 3'(GAP_BITS - 1) : 3'd0;

    state_t           state, state_nxt;
    logic             clkutx_d;
    logic             tick;
    logic [2:0]       cnt, cnt_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic [IDW-1:0]   last_grant, last_grant_nxt;
    logic [IDW-1:0]   grant_id_nxt;
    logic [NREQ-1:0]  ack_nxt;
    logic             txd_nxt;
    logic             frame_done_nxt;

    logic             pick_valid;
    logic [IDW-1:0]   pick_id;
    logic [NREQ-1:0]  pick_onehot;
    logic [7:0]       pick_byte;

    assign tick = clkUtx & ~clkutx_d;
    assign busy = (state != IDLE);

    // Requester i has priority distance (i - last_grant - 1) mod NREQ; the smallest pending one wins.
    always_comb begin : rr_pick
        int best_d;
        int d;
        best_d      = NREQ;
        d           = 0;
        pick_valid  = 1'b0;
        pick_id     = '0;
        pick_onehot = '0;
        pick_byte   = '0;
        for (int i = 0; i < NREQ; i++) begin
            d = i - int'(last_grant) - 1;
            if (d < 0) begin
                d = d + NREQ;
            end
            if (req[i] && (d < best_d)) begin
                best_d         = d;
                pick_valid     = 1'b1;
                pick_id        = IDW'(i);
                pick_onehot    = '0;
                pick_onehot[i] = 1'b1;
                pick_byte      = data[8*i +: 8];
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can leave one unassigned
    // and infer a latch.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        shreg_nxt      = shreg;
        txd_nxt        = txd;
        ack_nxt        = '0;
        grant_id_nxt   = grant_id;
        last_grant_nxt = last_grant;
        frame_done_nxt = 1'b0;

        case (state)
            IDLE: begin
                txd_nxt = 1'b1;
                if (pick_valid) begin
                    shreg_nxt      = pick_byte;
                    grant_id_nxt   = pick_id;
                    last_grant_nxt = pick_id;
                    ack_nxt        = pick_onehot;
                    state_nxt      = WAIT;
                end
            end
            WAIT: begin
                if (tick) begin
                    txd_nxt   = 1'b0;
                    state_nxt = START;
                end
            end
            START: begin
                if (tick) begin
                    txd_nxt   = shreg[0];
                    shreg_nxt = {1'b0, shreg[7:1]};
                    cnt_nxt   = 3'd0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (cnt == 3'd7) begin
                        txd_nxt   = 1'b1;
                        cnt_nxt   = 3'd0;
                        state_nxt = STOP;
                    end else begin
                        txd_nxt   = shreg[0];
                        shreg_nxt = {1'b0, shreg[7:1]};
                        cnt_nxt   = cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (cnt == STOP_LAST) begin
                        frame_done_nxt = 1'b1;
                        cnt_nxt        = 3'd0;
                        state_nxt      = (GAP_BITS == 0) ? IDLE : GAP;
                    end else begin
                        cnt_nxt = cnt + 3'd1;
                    end
                end
            end
            GAP: begin
                txd_nxt = 1'b1;
                if (tick) begin
                    if (cnt == GAP_LAST) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 3'd1;
                    end
                end
            end
            default: begin
                txd_nxt   = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    // clkutx_d resets high so a baud clock that is already high at release is not seen as a tick.
    always_ff @(posedge clk10mhz) begin
        if (!rst_n) begin
            state      <= IDLE;
            clkutx_d   <= 1'b1;
            cnt        <= 3'd0;
            shreg      <= 8'd0;
            last_grant <= IDW'(NREQ - 1);
            grant_id   <= '0;
            ack        <= '0;
            txd        <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            clkutx_d   <= clkUtx;
            cnt        <= cnt_nxt;
            shreg      <= shreg_nxt;
            last_grant <= last_grant_nxt;
            grant_id   <= grant_id_nxt;
            ack        <= ack_nxt;
            txd        <= txd_nxt;
            frame_done <= frame_done_nxt;
        end
    end

endmodule
